e203_dma_icb_arb: RTL and testbench

- Two-master to one-slave ICB arbiter that shares one memory-side ICB port between the CPU data port (m0) and the DMA engine master port (m1).
- Sits between the core/DMA and the system memory fabric.
- Grants commands round-robin and locks each grant until the command handshake completes.
- Tracks outstanding commands in an in-order ID FIFO so each response is routed back to the master that issued it.

---
 rtl/e203_dma_icb_arb.sv | 219 +++++++++++++++++++++
 tb/tb_e203_dma_icb_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_dma_icb_arb.sv
// ============================================================================
// Module   : e203_dma_icb_arb
// Purpose  : Two-master (m0 = CPU, m1 = DMA) to one-slave ICB arbiter.
//            Commands are granted round-robin and locked until their
//            handshake completes. An in-order ID FIFO routes each response
//            back to the master that issued the command.
// Options  : E203_DMA_ARB_FIXED_PRIO_EN - when defined, m0 always wins a
//            contended unlocked grant and no round-robin pointer exists.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e203_dma_icb_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int OUTS_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst,

  // Master 0 (CPU)
  input  logic                m0_icb_cmd_valid,
  output logic                m0_icb_cmd_ready,
  input  logic [ADDR_W-1:0]   m0_icb_cmd_addr,
  input  logic                m0_icb_cmd_read,
  input  logic [DATA_W-1:0]   m0_icb_cmd_wdata,
  input  logic [DATA_W/8-1:0] m0_icb_cmd_wmask,
  output logic                m0_icb_rsp_valid,
  input  logic                m0_icb_rsp_ready,
  output logic                m0_icb_rsp_err,
  output logic [DATA_W-1:0]   m0_icb_rsp_rdata,

  // Master 1 (DMA)
  input  logic                m1_icb_cmd_valid,
  output logic                m1_icb_cmd_ready,
  input  logic [ADDR_W-1:0]   m1_icb_cmd_addr,
  input  logic                m1_icb_cmd_read,
  input  logic [DATA_W-1:0]   m1_icb_cmd_wdata,
  input  logic [DATA_W/8-1:0] m1_icb_cmd_wmask,
  output logic                m1_icb_rsp_valid,
  input  logic                m1_icb_rsp_ready,
  output logic                m1_icb_rsp_err,
  output logic [DATA_W-1:0]   m1_icb_rsp_rdata,

  // Slave (memory side)
  output logic                s_icb_cmd_valid,
  input  logic                s_icb_cmd_ready,
  output logic [ADDR_W-1:0]   s_icb_cmd_addr,
  output logic                s_icb_cmd_read,
  output logic [DATA_W-1:0]   s_icb_cmd_wdata,
  output logic [DATA_W/8-1:0] s_icb_cmd_wmask,
  input  logic                s_icb_rsp_valid,
  output logic                s_icb_rsp_ready,
  input  logic                s_icb_rsp_err,
  input  logic [DATA_W-1:0]   s_icb_rsp_rdata,

  // Status
  output logic [CNT_W-1:0]    arb_outs_cnt,
  output logic                arb_rsp_orphan
);

  localparam int PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(OUTS_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                  r_lock;
  logic                  r_lock_id;
  logic [OUTS_DEPTH-1:0] r_fifo;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_orphan;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic w_both_pick;
  logic w_grant;
  logic w_gnt_valid;
  logic w_full;
  logic w_empty;
  logic w_cmd_hs;
  logic w_head;
  logic w_to_m0;
  logic w_to_m1;
  logic w_rsp_hs;
  logic w_pop;

  assign w_full  = (r_cnt == c_FULL_CNT);
  assign w_empty = (r_cnt == '0);

`ifdef E203_DMA_ARB_FIXED_PRIO_EN
  // CPU always wins a contended, unlocked grant.
  assign w_both_pick = 1'b0;
`else
  logic r_rr_ptr;

  assign w_both_pick = r_rr_ptr;

  // Round-robin pointer moves to the other master after each accepted command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_cmd_hs) begin
      r_rr_ptr <= ~w_grant;
    end
  end
`endif

  // Grant selection: a pending lock overrides arbitration.
  always_comb begin
    w_grant = 1'b0;
    if (r_lock) begin
      w_grant = r_lock_id;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      w_grant = w_both_pick;
    end else if (m1_icb_cmd_valid) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Command path
  // --------------------------------------------------------------------------
  assign w_gnt_valid     = w_grant ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  assign s_icb_cmd_valid = w_gnt_valid & ~w_full;
  assign s_icb_cmd_addr  = w_grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign s_icb_cmd_read  = w_grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign s_icb_cmd_wdata = w_grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign s_icb_cmd_wmask = w_grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

  assign m0_icb_cmd_ready = s_icb_cmd_ready & ~w_grant & ~w_full;
  assign m1_icb_cmd_ready = s_icb_cmd_ready &  w_grant & ~w_full;

  assign w_cmd_hs = s_icb_cmd_valid & s_icb_cmd_ready;

  // Hold the grant on a stalled command so its payload stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_grant;
    end else if (w_cmd_hs) begin
      r_lock    <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Response path
  // --------------------------------------------------------------------------
  assign w_head  = r_fifo[r_rptr];
  assign w_to_m0 = ~w_empty & ~w_head;
  assign w_to_m1 = ~w_empty &  w_head;

  assign m0_icb_rsp_valid = s_icb_rsp_valid & w_to_m0;
  assign m0_icb_rsp_err   = w_to_m0 & s_icb_rsp_err;
  assign m0_icb_rsp_rdata = w_to_m0 ? s_icb_rsp_rdata : '0;

  assign m1_icb_rsp_valid = s_icb_rsp_valid & w_to_m1;
  assign m1_icb_rsp_err   = w_to_m1 & s_icb_rsp_err;
  assign m1_icb_rsp_rdata = w_to_m1 ? s_icb_rsp_rdata : '0;

  // With nothing outstanding, responses are swallowed so the slave never stalls.
  assign s_icb_rsp_ready = w_empty ? 1'b1
                         : (w_head ? m1_icb_rsp_ready : m0_icb_rsp_ready);

  assign w_rsp_hs = s_icb_rsp_valid & s_icb_rsp_ready;
  assign w_pop    = w_rsp_hs & ~w_empty;

  // In-order ID FIFO: push the granted master on accept, pop on response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_fifo[r_wptr] <= w_grant;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  // Outstanding counter tracks FIFO occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_cmd_hs && !w_pop) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_pop && !w_cmd_hs) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Flag a response that arrived with no owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_orphan <= 1'b0;
    end else begin
      r_orphan <= s_icb_rsp_valid & w_empty;
    end
  end

  assign arb_outs_cnt   = r_cnt;
  assign arb_rsp_orphan = r_orphan;

endmodule

`default_nettype wire

// File: tb/tb_e203_dma_icb_arb.sv
// ============================================================================
// Module   : tb_e203_dma_icb_arb
// Purpose  : Directed self-checking bench for e203_dma_icb_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e203_dma_icb_arb;

  logic        clk;
  logic        rst;

  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [31:0] m0_icb_rsp_rdata;

  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [31:0] m1_icb_rsp_rdata;

  logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
  logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
  logic [3:0]  s_icb_cmd_wmask;
  logic        s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
  logic [31:0] s_icb_rsp_rdata;

  logic [2:0]  arb_outs_cnt;
  logic        arb_rsp_orphan;

  int errors = 0;
  int checks = 0;
  logic exp_id [4];

  e203_dma_icb_arb #(
    .ADDR_W(32), .DATA_W(32), .OUTS_DEPTH(4), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata),
    .arb_outs_cnt(arb_outs_cnt), .arb_rsp_orphan(arb_rsp_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef E203_DMA_ARB_FIXED_PRIO_EN
    exp_id[0] = 1'b0; exp_id[1] = 1'b0; exp_id[2] = 1'b0; exp_id[3] = 1'b0;
`else
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
`endif
    rst = 1'b1;
    m0_icb_cmd_valid = 0; m0_icb_cmd_addr = '0; m0_icb_cmd_read = 0;
    m0_icb_cmd_wdata = '0; m0_icb_cmd_wmask = '0; m0_icb_rsp_ready = 1;
    m1_icb_cmd_valid = 0; m1_icb_cmd_addr = '0; m1_icb_cmd_read = 0;
    m1_icb_cmd_wdata = '0; m1_icb_cmd_wmask = '0; m1_icb_rsp_ready = 1;
    s_icb_cmd_ready = 0; s_icb_rsp_valid = 0; s_icb_rsp_err = 0; s_icb_rsp_rdata = '0;

    // ---------------- Reset state ----------------
    step(); step();
    chk("rst_s_cmd_valid", s_icb_cmd_valid, 0);
    chk("rst_m0_cmd_ready", m0_icb_cmd_ready, 0);
    chk("rst_m1_cmd_ready", m1_icb_cmd_ready, 0);
    chk("rst_m0_rsp_valid", m0_icb_rsp_valid, 0);
    chk("rst_m1_rsp_valid", m1_icb_rsp_valid, 0);
    chk("rst_s_rsp_ready", s_icb_rsp_ready, 1);
    chk("rst_cnt", arb_outs_cnt, 0);
    chk("rst_orphan", arb_rsp_orphan, 0);
    rst = 1'b0;
    s_icb_cmd_ready = 1;

    // ---------------- Contended grants, fill to full ----------------
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h0000_0100; m0_icb_cmd_read = 1;
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h0000_0200; m1_icb_cmd_read = 0;
    m1_icb_cmd_wdata = 32'h1234_5678; m1_icb_cmd_wmask = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_s_valid", k), s_icb_cmd_valid, 1);
      chk($sformatf("rr%0d_m0_ready", k), m0_icb_cmd_ready, !exp_id[k]);
      chk($sformatf("rr%0d_m1_ready", k), m1_icb_cmd_ready, exp_id[k]);
      chk($sformatf("rr%0d_addr", k), s_icb_cmd_addr, exp_id[k] ? 32'h200 : 32'h100);
      step();
    end
    #1;
    chk("full_cnt", arb_outs_cnt, 4);
    chk("full_s_valid", s_icb_cmd_valid, 0);
    chk("full_m0_ready", m0_icb_cmd_ready, 0);
    chk("full_m1_ready", m1_icb_cmd_ready, 0);

    // ---------------- Drain in order ----------------
    m1_icb_cmd_valid = 0;
    s_icb_rsp_valid = 1;
    for (int k = 0; k < 4; k++) begin
      s_icb_rsp_rdata = 32'h1000 + k;
      #1;
      if (k == 0) chk("full_pop_s_valid", s_icb_cmd_valid, 0);
      chk($sformatf("drain%0d_m0_valid", k), m0_icb_rsp_valid, !exp_id[k]);
      chk($sformatf("drain%0d_m1_valid", k), m1_icb_rsp_valid, exp_id[k]);
      chk($sformatf("drain%0d_rdata", k),
          exp_id[k] ? m1_icb_rsp_rdata : m0_icb_rsp_rdata, 32'h1000 + k);
      chk($sformatf("drain%0d_s_ready", k), s_icb_rsp_ready, 1);
      step();
      m0_icb_cmd_valid = 0;
    end
    s_icb_rsp_valid = 0;
    #1;
    chk("drain_cnt", arb_outs_cnt, 0);

    // ---------------- Single m0 read ----------------
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h2000_0000; m0_icb_cmd_read = 1;
    #1;
    chk("rd_m0_ready", m0_icb_cmd_ready, 1);
    chk("rd_m1_ready", m1_icb_cmd_ready, 0);
    chk("rd_addr", s_icb_cmd_addr, 32'h2000_0000);
    chk("rd_read", s_icb_cmd_read, 1);
    step();
    m0_icb_cmd_valid = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hA5A5_A5A5;
    #1;
    chk("rd_cnt1", arb_outs_cnt, 1);
    chk("rd_m0_rsp_valid", m0_icb_rsp_valid, 1);
    chk("rd_m0_rdata", m0_icb_rsp_rdata, 32'hA5A5_A5A5);
    chk("rd_m1_rsp_valid", m1_icb_rsp_valid, 0);
    chk("rd_m1_rdata", m1_icb_rsp_rdata, 0);
    step();
    s_icb_rsp_valid = 0;
    #1;
    chk("rd_cnt0", arb_outs_cnt, 0);
    chk("rd_no_orphan", arb_rsp_orphan, 0);

    // ---------------- Locked m1 write under stall ----------------
    s_icb_cmd_ready = 0;
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h3000_0000; m1_icb_cmd_read = 0;
    m1_icb_cmd_wdata = 32'hCAFE_F00D; m1_icb_cmd_wmask = 4'hF;
    #1;
    chk("lk_s_valid", s_icb_cmd_valid, 1);
    chk("lk_addr0", s_icb_cmd_addr, 32'h3000_0000);
    step();
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h2000_0040; m0_icb_cmd_read = 1;
    m0_icb_cmd_wmask = 4'h3;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("lk%0d_addr", k), s_icb_cmd_addr, 32'h3000_0000);
      chk($sformatf("lk%0d_wmask", k), s_icb_cmd_wmask, 4'hF);
      chk($sformatf("lk%0d_m0_ready", k), m0_icb_cmd_ready, 0);
      step();
    end
    s_icb_cmd_ready = 1;
    #1;
    chk("lk_rel_m1_ready", m1_icb_cmd_ready, 1);
    chk("lk_rel_m0_ready", m0_icb_cmd_ready, 0);
    chk("lk_rel_wdata", s_icb_cmd_wdata, 32'hCAFE_F00D);
    step();
    m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0;
    #1;
    chk("lk_cnt", arb_outs_cnt, 1);

    // ---------------- m1 error response with backpressure ----------------
    m1_icb_rsp_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_err = 1; s_icb_rsp_rdata = 32'h0000_DEAD;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("err%0d_m1_valid", k), m1_icb_rsp_valid, 1);
      chk($sformatf("err%0d_m1_err", k), m1_icb_rsp_err, 1);
      chk($sformatf("err%0d_m0_err", k), m0_icb_rsp_err, 0);
      chk($sformatf("err%0d_s_ready", k), s_icb_rsp_ready, 0);
      chk($sformatf("err%0d_cnt", k), arb_outs_cnt, 1);
      step();
    end
    m1_icb_rsp_ready = 1;
    #1;
    chk("err_s_ready", s_icb_rsp_ready, 1);
    step();
    s_icb_rsp_valid = 0; s_icb_rsp_err = 0;
    #1;
    chk("err_cnt0", arb_outs_cnt, 0);

    // ---------------- Orphan response ----------------
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h0BAD_0BAD;
    #1;
    chk("orph_s_ready", s_icb_rsp_ready, 1);
    chk("orph_m0_valid", m0_icb_rsp_valid, 0);
    chk("orph_m1_valid", m1_icb_rsp_valid, 0);
    chk("orph_pre", arb_rsp_orphan, 0);
    step();
    s_icb_rsp_valid = 0;
    #1;
    chk("orph_pulse", arb_rsp_orphan, 1);
    step();
    chk("orph_clear", arb_rsp_orphan, 0);

    // ---------------- Reset with outstanding commands ----------------
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h2000_0080;
    step();
    m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h3000_0080;
    step();
    m1_icb_cmd_valid = 0;
    #1;
    chk("mr_cnt2", arb_outs_cnt, 2);
    rst = 1'b1;
    #1;
    chk("mr_cnt_async", arb_outs_cnt, 0);
    chk("mr_s_ready", s_icb_rsp_ready, 1);
    step();
    rst = 1'b0;
    s_icb_rsp_valid = 1;
    #1;
    chk("mr_m0_valid", m0_icb_rsp_valid, 0);
    chk("mr_m1_valid", m1_icb_rsp_valid, 0);
    step();
    s_icb_rsp_valid = 0;
    #1;
    chk("mr_orphan", arb_rsp_orphan, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
